// File: rtl/mux2to1_led_arbiter_pkg.sv
// Shared definitions for the two-requester LED arbiter: state encodings and the default hold length.
package mux2to1_led_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam int DEF_HOLD_CYCLES = 8;

    // Ownership state for requester index i (0 = X, 1 = Y).
    function automatic state_t own_state(input logic i);
        return i ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/mux2to1_led_arbiter_mux.sv
// One-bit 2:1 mux: m follows x when s=0, y when s=1.
module mux_lbit_2to1 (
    input  logic x,
    input  logic y,
    input  logic s,
    output logic m
);

    assign m = s ? y : x;

endmodule

// File: rtl/mux2to1_led_arbiter.sv
// Round-robin arbiter sharing one registered LED between requesters X and Y.
// Define MUX_ARB_LOCK_EN to add the 'lock' input that lets the owner ignore hold expiry.
module mux2to1_led_arbiter
    import mux2to1_led_arbiter_pkg::*;
#(
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       x,
    input  logic       y,
`ifdef MUX_ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic [1:0] gnt,
    output logic       sel,
    output logic       led,
    output logic       busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             last_reg, last_next;
    logic             sel_next;
    logic             mux_out;
    logic             own_idx;
    logic             expired;
    logic             hold_lock;

`ifdef MUX_ARB_LOCK_EN
    assign hold_lock = lock;
`else
    assign hold_lock = 1'b0;
`endif

    assign own_idx = (state_reg == ST_OWN1);
    assign expired = (cnt_reg == CNT_MAX);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        last_next  = last_reg;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                case (req)
                    2'b11:   state_next = own_state(~last_reg);
                    2'b01:   state_next = ST_OWN0;
                    2'b10:   state_next = ST_OWN1;
                    default: state_next = ST_IDLE;
                endcase
            end
            ST_OWN0, ST_OWN1: begin
                // Release takes priority over expiry in the same cycle.
                if (!req[own_idx]) begin
                    state_next = ST_IDLE;
                    last_next  = own_idx;
                    cnt_next   = '0;
                end else if (expired && hold_lock) begin
                    cnt_next = cnt_reg;
                end else if (expired && req[~own_idx]) begin
                    state_next = ST_GAP;
                    last_next  = own_idx;
                    cnt_next   = '0;
                end else if (expired) begin
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_GAP: begin
                cnt_next = '0;
                if (req[~last_reg])
                    state_next = own_state(~last_reg);
                else if (req[last_reg])
                    state_next = own_state(last_reg);
                else
                    state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Select only moves on entry to an ownership state; it holds through IDLE and GAP.
    always_comb begin
        sel_next = sel;
        if (state_next == ST_OWN1)
            sel_next = 1'b1;
        else if (state_next == ST_OWN0)
            sel_next = 1'b0;
    end

    mux_lbit_2to1 u_mux (
        .x (x),
        .y (y),
        .s (sel_next),
        .m (mux_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            last_reg  <= 1'b1;
            gnt       <= 2'b00;
            sel       <= 1'b0;
            led       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            last_reg  <= last_next;
            gnt       <= {state_next == ST_OWN1, state_next == ST_OWN0};
            sel       <= sel_next;
            led       <= (state_next == ST_OWN0 || state_next == ST_OWN1) ? mux_out : 1'b0;
            busy      <= (state_next != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_mux2to1_led_arbiter.sv
// Self-checking bench for mux2to1_led_arbiter; adds lock checks when MUX_ARB_LOCK_EN is defined.
module tb_mux2to1_led_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic       x   = 1'b0;
    logic       y   = 1'b0;
`ifdef MUX_ARB_LOCK_EN
    logic       lock = 1'b0;
`endif
    logic [1:0] gnt;
    logic       sel;
    logic       led;
    logic       busy;

    always #5 clk = ~clk;

    mux2to1_led_arbiter dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .x    (x),
        .y    (y),
`ifdef MUX_ARB_LOCK_EN
        .lock (lock),
`endif
        .gnt  (gnt),
        .sel  (sel),
        .led  (led),
        .busy (busy)
    );

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic       x;
        logic       y;
        logic       lk;
        logic [1:0] gnt;
        logic       sel;
        logic       led;
        logic       busy;
        string      tag;
    } vec_t;

    typedef struct {
        logic [4:0] exp;
        string      tag;
    } sb_t;

    vec_t list_a[$];
    vec_t list_b[$];
    vec_t list_c[$];
    sb_t  sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void add(input int which, input logic r, input logic [1:0] rq,
                                input logic xv, input logic yv, input logic lk,
                                input logic [1:0] eg, input logic es, input logic el,
                                input logic eb, input string tag);
        vec_t v;
        v = '{r, rq, xv, yv, lk, eg, es, el, eb, tag};
        case (which)
            0:       list_a.push_back(v);
            1:       list_b.push_back(v);
            default: list_c.push_back(v);
        endcase
    endfunction

    task automatic check(input logic [4:0] act, input logic [4:0] exp, input string tag);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: gnt/sel/led/busy got %b want %b at %0t", tag, act, exp, $time);
        end else begin
            $display("[TB] ok %s gnt/sel/led/busy=%b", tag, act);
        end
    endtask

    task automatic apply(input vec_t v);
        sb_t e;
        @(negedge clk);
        rst = v.rst;
        req = v.req;
        x   = v.x;
        y   = v.y;
`ifdef MUX_ARB_LOCK_EN
        lock = v.lk;
`endif
        sb.push_back('{{v.gnt, v.sel, v.led, v.busy}, v.tag});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({gnt, sel, led, busy}, e.exp, e.tag);
    endtask

    initial begin
        // Reset held with both requesting: nothing granted.
        repeat (2) add(0, 1, 2'b11, 0, 0, 0, 2'b00, 0, 0, 0, "reset");
        // X alone for 20 cycles; x drops at step 5; counter rolls over without a gap.
        for (int k = 0; k < 20; k++) begin
            logic xv;
            xv = (k < 5);
            add(0, 0, 2'b01, xv, 0, 0, 2'b01, 0, xv, 1, "own0_hold");
        end
        add(0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, "release");
        add(0, 1, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, "rst_again");
        // Both requesting: 8 owner cycles then one blank gap, alternating X/Y.
        for (int r = 0; r < 3; r++) begin
            logic o;
            o = r[0];
            for (int k = 0; k < 8; k++)
                add(0, 0, 2'b11, 1, 0, 0, o ? 2'b10 : 2'b01, o, ~o, 1, "rr_own");
            add(0, 0, 2'b11, 1, 0, 0, 2'b00, o, 0, 1, "rr_gap");
        end
        // Y owns for 4 cycles, then drops while X waits: IDLE then X without a gap.
        repeat (4) add(0, 0, 2'b11, 1, 0, 0, 2'b10, 1, 0, 1, "own1_cnt");
        add(0, 0, 2'b01, 1, 0, 0, 2'b00, 1, 0, 0, "drop_req1");
        add(0, 0, 2'b01, 1, 0, 0, 2'b01, 0, 1, 1, "regrant0");
        add(0, 0, 2'b10, 1, 1, 0, 2'b00, 0, 0, 0, "own0_release");
        add(0, 0, 2'b10, 1, 1, 0, 2'b10, 1, 1, 1, "own1_enter");
        // After async reset, a tie goes to X.
        add(1, 1, 2'b11, 1, 1, 0, 2'b00, 0, 0, 0, "rst_hold");
        add(1, 0, 2'b11, 1, 1, 0, 2'b01, 0, 1, 1, "first_after_rst");
        repeat (12) add(2, 0, 2'b11, 1, 0, 1, 2'b01, 0, 1, 1, "lock_keep");
        add(2, 0, 2'b11, 1, 0, 0, 2'b00, 0, 0, 1, "lock_gap");
        add(2, 0, 2'b11, 1, 0, 0, 2'b10, 1, 0, 1, "lock_next");

        foreach (list_a[i]) apply(list_a[i]);

        // Reset asserted between edges while Y owns: outputs clear without a clock edge.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check({gnt, sel, led, busy}, 5'b00000, "async_rst");

        foreach (list_b[i]) apply(list_b[i]);
`ifdef MUX_ARB_LOCK_EN
        foreach (list_c[i]) apply(list_c[i]);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
